// File: rtl/tod_keeper.sv
// GPS-disciplined time-of-day keeper: loads UTC time from packets, advances it on
// each 1PPS edge and free-runs through short PPS outages before dropping sync.
`timescale 1ns/1ps

module tod_keeper #(
    parameter int CLKS_PER_SEC  = 10000000,
    parameter int PPS_MARGIN    = 10000,
    parameter int HOLDOVER_SECS = 60
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_pps,
    input  logic        i_packet_dv,
    input  logic [7:0]  i_year_h,
    input  logic [7:0]  i_year_l,
    input  logic [7:0]  i_month,
    input  logic [7:0]  i_day,
    input  logic [7:0]  i_hour,
    input  logic [7:0]  i_minutes,
    input  logic [7:0]  i_seconds,
    output logic [15:0] o_year,
    output logic [7:0]  o_month,
    output logic [7:0]  o_day,
    output logic [7:0]  o_hour,
    output logic [7:0]  o_minutes,
    output logic [7:0]  o_seconds,
    output logic        o_tick,
    output logic        o_locked,
    output logic        o_valid,
    output logic        o_load_err
);

    localparam int WD_LIMIT = CLKS_PER_SEC + PPS_MARGIN;
    localparam int WD_W     = $clog2(WD_LIMIT + 1);
    localparam int HO_W     = $clog2(HOLDOVER_SECS + 1);

    localparam logic [WD_W-1:0] WD_LOCK_LAST = WD_W'(WD_LIMIT - 1);
    localparam logic [WD_W-1:0] WD_HOLD_LAST = WD_W'(CLKS_PER_SEC - 1);
    localparam logic [WD_W-1:0] WD_RELOAD    = WD_W'(PPS_MARGIN);
    localparam logic [HO_W-1:0] HO_LAST      = HO_W'(HOLDOVER_SECS - 1);

    // Encoding puts o_locked on bit 0 and o_valid on bit 1, so both come straight from flops.
    typedef enum logic [1:0] {
        UNSYNC   = 2'b00,
        HOLDOVER = 2'b10,
        LOCKED   = 2'b11
    } state_t;

    typedef struct packed {
        logic [15:0] year;
        logic [7:0]  month;
        logic [7:0]  day;
        logic [7:0]  hour;
        logic [7:0]  minutes;
        logic [7:0]  seconds;
    } tod_t;

    function automatic logic [7:0] days_in_month(input logic [15:0] year, input logic [7:0] month);
        case (month)
            8'd4, 8'd6, 8'd9, 8'd11: days_in_month = 8'd30;
            8'd2:    days_in_month = (year[1:0] == 2'b00 && year != 16'd2100) ? 8'd29 : 8'd28;
            default: days_in_month = 8'd31;
        endcase
    endfunction

    function automatic logic tod_ok(input tod_t t);
        tod_ok = (t.year >= 16'd2000) && (t.year <= 16'd2099)
              && (t.month >= 8'd1) && (t.month <= 8'd12)
              && (t.day >= 8'd1) && (t.day <= days_in_month(t.year, t.month))
              && (t.hour <= 8'd23) && (t.minutes <= 8'd59) && (t.seconds <= 8'd59);
    endfunction

    function automatic tod_t inc_tod(input tod_t t);
        tod_t r;
        r = t;
        if (t.seconds != 8'd59) r.seconds = t.seconds + 8'd1;
        else begin
            r.seconds = 8'd0;
            if (t.minutes != 8'd59) r.minutes = t.minutes + 8'd1;
            else begin
                r.minutes = 8'd0;
                if (t.hour != 8'd23) r.hour = t.hour + 8'd1;
                else begin
                    r.hour = 8'd0;
                    if (t.day < days_in_month(t.year, t.month)) r.day = t.day + 8'd1;
                    else begin
                        r.day = 8'd1;
                        if (t.month != 8'd12) r.month = t.month + 8'd1;
                        else begin
                            r.month = 8'd1;
                            r.year  = t.year + 16'd1;
                        end
                    end
                end
            end
        end
        return r;
    endfunction

    logic            pps_meta, pps_sync, pps_prev;
    logic            pps_edge;
    state_t          state;
    logic [WD_W-1:0] wd;
    logic [HO_W-1:0] ho_cnt;
    tod_t            tod;
    tod_t            pkt_tod, base_tod;
    logic            pkt_ok, pps_take, lk_expire, ho_expire, advance;

    assign pps_edge = pps_sync & ~pps_prev;

    always_comb begin
        pkt_tod   = {i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds};
        pkt_ok    = i_packet_dv && tod_ok(pkt_tod);
        // A PPS edge also counts in UNSYNC when a valid packet lands on the same cycle.
        pps_take  = pps_edge && (state != UNSYNC || pkt_ok);
        lk_expire = !pps_edge && state == LOCKED   && wd == WD_LOCK_LAST;
        ho_expire = !pps_edge && state == HOLDOVER && wd == WD_HOLD_LAST;
        advance   = pps_take || lk_expire || ho_expire;
        base_tod  = pkt_ok ? pkt_tod : tod;
    end

    // NOTE: non-blocking assignments throughout, so every register here sees pre-edge values.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            pps_meta   <= 1'b0;
            pps_sync   <= 1'b0;
            pps_prev   <= 1'b0;
            state      <= UNSYNC;
            wd         <= '0;
            ho_cnt     <= '0;
            tod        <= '0;
            o_tick     <= 1'b0;
            o_load_err <= 1'b0;
        end else begin
            pps_meta   <= i_pps;
            pps_sync   <= pps_meta;
            pps_prev   <= pps_sync;
            o_tick     <= advance;
            o_load_err <= i_packet_dv && !pkt_ok;

            if (advance)     tod <= inc_tod(base_tod);
            else if (pkt_ok) tod <= pkt_tod;

            if (pps_take) begin
                state  <= LOCKED;
                wd     <= '0;
                ho_cnt <= '0;
            end else if (lk_expire) begin
                state <= HOLDOVER;
                wd    <= WD_RELOAD;
            end else if (ho_expire) begin
                wd <= '0;
                if (ho_cnt == HO_LAST) begin
                    state  <= UNSYNC;
                    ho_cnt <= '0;
                end else begin
                    ho_cnt <= ho_cnt + 1'b1;
                end
            end else if (pkt_ok && state == UNSYNC) begin
                state <= LOCKED;
                wd    <= '0;
            end else if (state != UNSYNC) begin
                wd <= wd + 1'b1;
            end
        end
    end

    assign o_year    = tod.year;
    assign o_month   = tod.month;
    assign o_day     = tod.day;
    assign o_hour    = tod.hour;
    assign o_minutes = tod.minutes;
    assign o_seconds = tod.seconds;
    assign o_locked  = state[0];
    assign o_valid   = state[1];

endmodule

// File: tb/tb_tod_keeper.sv
// Directed bench for tod_keeper with shortened second/margin/holdover parameters;
// all expected times and tick gaps are hand-computed constants.
`timescale 1ns/1ps

module tb_tod_keeper;

    localparam int CPS    = 20;
    localparam int MARGIN = 4;
    localparam int HOLD   = 3;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_pps;
    logic        i_packet_dv;
    logic [7:0]  i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds;
    logic [15:0] o_year;
    logic [7:0]  o_month, o_day, o_hour, o_minutes, o_seconds;
    logic        o_tick, o_locked, o_valid, o_load_err;
    logic [63:0] now_tod;

    int n_checks = 0;
    int n_pass   = 0;
    int n;

    tod_keeper #(
        .CLKS_PER_SEC (CPS),
        .PPS_MARGIN   (MARGIN),
        .HOLDOVER_SECS(HOLD)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_pps      (i_pps),
        .i_packet_dv(i_packet_dv),
        .i_year_h   (i_year_h),
        .i_year_l   (i_year_l),
        .i_month    (i_month),
        .i_day      (i_day),
        .i_hour     (i_hour),
        .i_minutes  (i_minutes),
        .i_seconds  (i_seconds),
        .o_year     (o_year),
        .o_month    (o_month),
        .o_day      (o_day),
        .o_hour     (o_hour),
        .o_minutes  (o_minutes),
        .o_seconds  (o_seconds),
        .o_tick     (o_tick),
        .o_locked   (o_locked),
        .o_valid    (o_valid),
        .o_load_err (o_load_err)
    );

    always #5 i_clk = ~i_clk;

    assign now_tod = {8'h00, o_year, o_month, o_day, o_hour, o_minutes, o_seconds};

    function automatic logic [63:0] tod(input int y, input int mo, input int d,
                                        input int h, input int mi, input int s);
        return {8'h00, 16'(y), 8'(mo), 8'(d), 8'(h), 8'(mi), 8'(s)};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic send_pkt(input int y, input int mo, input int d,
                            input int h, input int mi, input int s);
        i_year_h    = 8'(y >> 8);
        i_year_l    = 8'(y);
        i_month     = 8'(mo);
        i_day       = 8'(d);
        i_hour      = 8'(h);
        i_minutes   = 8'(mi);
        i_seconds   = 8'(s);
        i_packet_dv = 1'b1;
        step();
        i_packet_dv = 1'b0;
    endtask

    // Update is visible after the 3rd edge that sees i_pps high.
    task automatic pps_rise();
        i_pps = 1'b1;
        repeat (3) step();
    endtask

    task automatic wait_tick(input int limit, output int cycles);
        cycles = 0;
        do begin
            step();
            cycles++;
        end while (!o_tick && cycles < limit);
    endtask

    initial begin
        i_rst = 1'b0;
        i_pps = 1'b0;
        i_packet_dv = 1'b0;
        {i_year_h, i_year_l, i_month, i_day, i_hour, i_minutes, i_seconds} = '0;
        repeat (3) step();
        check("rst_time", now_tod, 64'd0);
        check("rst_flags", {o_tick, o_locked, o_valid, o_load_err}, 4'b0000);
        i_rst = 1'b1;
        step();

        pps_rise();
        check("unsync_pps_tick", o_tick, 1'b0);
        check("unsync_pps_locked", o_locked, 1'b0);
        i_pps = 1'b0;

        send_pkt(2024, 2, 28, 23, 59, 59);
        check("load_time", now_tod, tod(2024, 2, 28, 23, 59, 59));
        check("load_no_tick", o_tick, 1'b0);
        check("load_state", {o_locked, o_valid, o_load_err}, 3'b110);
        pps_rise();
        check("leap_time", now_tod, tod(2024, 2, 29, 0, 0, 0));
        check("leap_tick", o_tick, 1'b1);
        step();
        check("leap_tick_width", o_tick, 1'b0);
        i_pps = 1'b0;

        send_pkt(2023, 12, 31, 23, 59, 59);
        pps_rise();
        check("year_carry", now_tod, tod(2024, 1, 1, 0, 0, 0));
        i_pps = 1'b0;
        send_pkt(2100, 2, 28, 23, 59, 59);
        check("y2100_err", o_load_err, 1'b1);
        check("y2100_time", now_tod, tod(2024, 1, 1, 0, 0, 0));
        check("y2100_locked", o_locked, 1'b1);
        step();
        check("err_width", o_load_err, 1'b0);

        send_pkt(2099, 12, 31, 23, 59, 59);
        pps_rise();
        check("century_time", now_tod, tod(2100, 1, 1, 0, 0, 0));
        check("century_valid", {o_locked, o_valid}, 2'b11);
        i_pps = 1'b0;

        send_pkt(2024, 13, 1, 0, 0, 0);
        check("month13_err", o_load_err, 1'b1);
        check("month13_time", now_tod, tod(2100, 1, 1, 0, 0, 0));
        send_pkt(2024, 4, 31, 0, 0, 0);
        check("apr31_err", o_load_err, 1'b1);
        check("apr31_time", now_tod, tod(2100, 1, 1, 0, 0, 0));
        check("apr31_state", {o_locked, o_valid}, 2'b11);
        send_pkt(2023, 2, 29, 0, 0, 0);
        check("feb29_noleap_err", o_load_err, 1'b1);

        // Packet lands on the same edge as the PPS update.
        i_pps = 1'b1;
        step();
        step();
        send_pkt(2024, 6, 15, 12, 0, 0);
        check("collide_time", now_tod, tod(2024, 6, 15, 12, 0, 1));
        check("collide_tick", o_tick, 1'b1);
        i_pps = 1'b0;

        wait_tick(100, n);
        check("ho_entry_gap", n, CPS + MARGIN);
        check("ho_entry_time", now_tod, tod(2024, 6, 15, 12, 0, 2));
        check("ho_entry_state", {o_locked, o_valid}, 2'b01);
        wait_tick(100, n);
        check("ho_first_gap", n, CPS - MARGIN);
        check("ho_first_time", now_tod, tod(2024, 6, 15, 12, 0, 3));
        wait_tick(100, n);
        check("ho_second_gap", n, CPS);
        check("ho_second_state", {o_locked, o_valid}, 2'b01);
        pps_rise();
        check("relock_tick", o_tick, 1'b1);
        check("relock_time", now_tod, tod(2024, 6, 15, 12, 0, 5));
        check("relock_state", {o_locked, o_valid}, 2'b11);
        i_pps = 1'b0;

        wait_tick(100, n);
        check("ex_entry_gap", n, CPS + MARGIN);
        wait_tick(100, n);
        check("ex_gap1", n, CPS - MARGIN);
        wait_tick(100, n);
        check("ex_gap2", n, CPS);
        check("ex_still_valid", o_valid, 1'b1);
        wait_tick(100, n);
        check("ex_gap3", n, CPS);
        check("ex_time", now_tod, tod(2024, 6, 15, 12, 0, 9));
        check("ex_state", {o_locked, o_valid}, 2'b00);
        wait_tick(60, n);
        check("ex_no_more_ticks", n, 60);
        check("ex_tick_low", o_tick, 1'b0);
        pps_rise();
        check("ex_pps_no_tick", o_tick, 1'b0);
        check("ex_time_held", now_tod, tod(2024, 6, 15, 12, 0, 9));
        check("ex_pps_unsync", o_locked, 1'b0);
        i_pps = 1'b0;

        send_pkt(2024, 3, 10, 8, 0, 0);
        wait_tick(100, n);
        check("rst_ho_entry", {o_locked, o_valid}, 2'b01);
        repeat (5) step();
        i_rst = 1'b0;
        step();
        i_rst = 1'b1;
        check("rst_ho_time", now_tod, 64'd0);
        check("rst_ho_flags", {o_tick, o_locked, o_valid, o_load_err}, 4'b0000);
        wait_tick(60, n);
        check("rst_ho_no_pending", n, 60);
        check("rst_ho_time_after", now_tod, 64'd0);

        i_rst = 1'b0;
        send_pkt(2024, 5, 5, 5, 5, 5);
        i_rst = 1'b1;
        step();
        check("rst_load_time", now_tod, 64'd0);
        check("rst_load_state", {o_locked, o_valid}, 2'b00);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
